sdc_request_arbiter: RTL
========================

// Module: sdc_request_arbiter
// PURPOSE
//  N-channel successor to the fixed floppy/SCSI sd-card demux in the data controller.
//  Latches read/write requests from NCH storage clients (IWM drives, SCSI targets), grants them round-robin,
//  and drives sdc_lba/sdc_rd/sdc_wr as a level handshake with the sd-card host.
//  Routes sdc_busy and buffer data to/from the granted channel, absorbs writes to write-protected channels,
//  and keeps one activity-LED timer per channel. Sits between the controllers and the top-level sdc_* port.
// PARAMETERS
//  NCH      4   number of client channels (2..8)
//  LBA_W    32  LBA width of each client (narrower clients zero-extend at the instantiation)
//  LED_W    16  activity timer width; LED stays lit for 2^LED_W-1 clk after a grant
// PORTS
//  clk           in   1         16 MHz system clock
//  reset         in   1         synchronous, active-high
//  req_rd        in   NCH       per-channel read request (pulse or level)
//  req_wr        in   NCH       per-channel write request (pulse or level)
//  req_lba       in   NCH*LBA_W per-channel LBA; channel i at [i*LBA_W +: LBA_W]
//  req_dout      in   NCH*8     per-channel buffer byte toward the card (writes)
//  wprot         in   NCH       per-channel write protect
//  ch_busy       out  NCH       per-channel busy/ack back to the clients
//  sdc_lba       out  LBA_W     LBA of the granted channel
//  sdc_rd        out  NCH       one-hot read strobe to the host
//  sdc_wr        out  NCH       one-hot write strobe to the host
//  sdc_data_out  out  8         req_dout of the granted channel (combinational mux)
//  sdc_busy      in   1         host busy
//  grant_id      out  $clog2(NCH) index of the channel currently or last granted
//  led           out  NCH       activity indicators
// BEHAVIOUR
//  Reset
//   - All outputs are 0 and grant_id=0. Pending bits, LED timers and the RR pointer are 0. State is IDLE.
//   - A reset during an operation drops sdc_rd/sdc_wr on the next clk. No ack is produced.
//  Pending capture
//   - Each clk, pend_rd[i] |= req_rd[i] and pend_wr[i] |= req_wr[i].
//   - A repeat request on a bit that is already pending merges into it.
//   - A pending bit is cleared only when its operation completes. A request arriving in that same cycle re-sets the bit.
//  Write protect
//   - If pend_wr[i] && wprot[i], the write is never issued to the host.
//   - While in IDLE, the bit is cleared and ch_busy[i] pulses for 1 clk (pseudo-ack).
//   - This takes priority over arbitration in that cycle.
//  Arbitration (IDLE)
//   - Candidates are the channels with an unprotected pending op.
//   - Scan starts at rr_ptr, then rr_ptr+1 ... wrapping modulo NCH. The first candidate wins.
//   - If the winner has both rd and wr pending, rd is served first and wr stays pending.
//   - On a win: latch grant_id and op, set rr_ptr=winner+1 (wrapping NCH-1 to 0), load led timer[winner] with all-ones, go to SETUP.
//  FSM  IDLE -> SETUP -> REQ -> XFER -> IDLE
//   - SETUP (1 clk): sdc_lba holds the latched LBA. sdc_rd/sdc_wr stay 0, so the LBA is stable 1 clk before the strobe.
//   - REQ: drive the one-hot bit for grant_id on sdc_rd or sdc_wr. Hold it until sdc_busy=1, then drop it and go to XFER.
//   - XFER: wait for sdc_busy=0. Then clear the served pending bit and go to IDLE.
//   - Minimum spacing between two grants is therefore 4 clk.
//  Muxing
//   - ch_busy[grant_id] = sdc_busy while in REQ or XFER. All other ch_busy bits are 0 except write-protect pseudo-acks.
//   - sdc_lba is registered at grant and stable until the next grant.
//   - sdc_data_out = req_dout[grant_id] at all times, so it follows the client's buffer address with no added latency.
//  LED timers
//   - Each timer decrements by 1 per clk while non-zero. led[i] = (timer[i] != 0).
//   - A reload while a timer is non-zero restarts it at all-ones.
//  Boundaries
//   - All NCH channels pending at once: each is served once before any channel is served a second time.
//   - sdc_busy already 1 on entry to REQ: the strobe is held 1 clk, then the FSM goes to XFER.
//   - sdc_busy never rises: the FSM stays in REQ. There is no timeout; the host guarantees an ack.
// STRUCTURE
//  Package sdc_arb_pkg
//   - typedef enum {IDLE, SETUP, REQ, XFER} arb_state_t
//   - typedef enum {OP_RD, OP_WR} arb_op_t
//   - function rr_pick(pending, ptr) -> winner index plus valid flag
//  Sub-module activity_led_timer #(LED_W)
//   - ports clk, reset, load, active
//   - instantiated NCH times via generate
// TESTING
//  1. Reset: hold reset 3 clk with req_rd=4'b1111 -> all outputs 0 during reset, no pending bit survives, led=0.
//  2. Single read: req_rd[2] pulse, req_lba[2]=32'h1234
//     -> sdc_lba=32'h1234 from SETUP, sdc_rd=4'b0100 exactly 1 clk later;
//     host busy for 10 clk -> ch_busy[2] high for those 10 clk, then the pend_rd[2] bit clears.
//  3. Round robin: rd pulses on ch0..ch3 in one cycle with rr_ptr=0 -> grant order 0,1,2,3;
//     then a new rd on ch0 and ch1 -> ch0 is next.
//  4. Write protect: wprot[1]=1 plus req_wr[1] -> sdc_wr stays 0, ch_busy[1] pulses 1 clk, no LED for channel 1.
//  5. Simultaneous rd+wr on ch3 -> sdc_rd=4'b1000 served, then sdc_wr=4'b1000 served as a separate grant.
//  6. Reset in XFER with sdc_busy=1 -> next clk state IDLE, sdc_rd/sdc_wr=0, ch_busy=0.
//     A fresh req_rd[0] after reset is granted normally.

Source files
------------

// File: rtl/sdc_arb_pkg.sv
// Shared types and the round-robin picker for the sd-card request arbiter.
// The picker works on a fixed 8-bit vector so that any channel count up to 8 can use it.
package sdc_arb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, REQ, XFER} arb_state_t;
  typedef enum logic {OP_RD, OP_WR} arb_op_t;

  localparam int MAX_NCH = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(
    input logic [MAX_NCH-1:0] pending,
    input logic [2:0]         ptr,
    input int                 nch
  );
    rr_pick_t   r;
    logic [3:0] idx;
    r = '0;
    for (int k = 0; k < MAX_NCH; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(nch)) idx = idx - 4'(nch);
      if (k < nch && !r.valid && pending[idx[2:0]]) begin
        r.valid = 1'b1;
        r.idx   = idx[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/activity_led_timer.sv
// Per-channel activity timer: reloads to all-ones on load, counts down to zero.
// The LED is lit whenever the count is non-zero.
module activity_led_timer #(
  parameter int LED_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic active
);

  logic [LED_W-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (load) timer_d = '1;
    else if (timer_q != '0) timer_d = timer_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) timer_q <= '0;
    else timer_q <= timer_d;
  end

  assign active = (timer_q != '0);

endmodule

// File: rtl/sdc_request_arbiter.sv
// Round-robin arbiter between NCH storage clients and the single sd-card host port.
// Grants run IDLE -> SETUP -> REQ -> XFER with a level handshake on sdc_busy.
module sdc_request_arbiter
  import sdc_arb_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int LBA_W = 32,
  parameter int LED_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         req_rd,
  input  logic [NCH-1:0]         req_wr,
  input  logic [NCH*LBA_W-1:0]   req_lba,
  input  logic [NCH*8-1:0]       req_dout,
  input  logic [NCH-1:0]         wprot,
  output logic [NCH-1:0]         ch_busy,
  output logic [LBA_W-1:0]       sdc_lba,
  output logic [NCH-1:0]         sdc_rd,
  output logic [NCH-1:0]         sdc_wr,
  output logic [7:0]             sdc_data_out,
  input  logic                   sdc_busy,
  output logic [$clog2(NCH)-1:0] grant_id,
  output logic [NCH-1:0]         led
);

  localparam int IW = $clog2(NCH);

  arb_state_t         state_q, state_d;
  arb_op_t            op_q, op_d;
  logic [IW-1:0]      gid_q, gid_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [LBA_W-1:0]   lba_q, lba_d;
  logic [NCH-1:0]     prd_q, prd_d;
  logic [NCH-1:0]     pwr_q, pwr_d;
  logic [NCH-1:0]     wp_mask, cand, gnt_oh;
  logic [NCH-1:0]     clr_rd, clr_wr, led_load;
  logic [MAX_NCH-1:0] pick_vec;
  rr_pick_t           pick;
  logic [IW-1:0]      win;

  always_comb begin
    wp_mask  = pwr_q & wprot;
    cand     = prd_q | (pwr_q & ~wprot);
    pick_vec = '0;
    pick_vec[NCH-1:0] = cand;
    pick     = rr_pick(pick_vec, 3'(rr_q), NCH);
    win      = pick.idx[IW-1:0];
    gnt_oh   = '0;
    gnt_oh[gid_q] = 1'b1;

    state_d  = state_q;
    op_d     = op_q;
    gid_d    = gid_q;
    rr_d     = rr_q;
    lba_d    = lba_q;
    clr_rd   = '0;
    clr_wr   = '0;
    led_load = '0;

    unique case (state_q)
      IDLE: begin
        // protected writes are absorbed before any new grant
        if (|wp_mask) begin
          clr_wr = wp_mask;
        end else if (pick.valid) begin
          gid_d    = win;
          op_d     = prd_q[win] ? OP_RD : OP_WR;
          rr_d     = (int'(win) == NCH - 1) ? '0 : IW'(win + 1'b1);
          lba_d    = req_lba[int'(win)*LBA_W +: LBA_W];
          led_load[win] = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = REQ;
      REQ: if (sdc_busy) state_d = XFER;
      XFER: begin
        if (!sdc_busy) begin
          if (op_q == OP_RD) clr_rd = gnt_oh;
          else clr_wr = gnt_oh;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    prd_d = (prd_q & ~clr_rd) | req_rd;
    pwr_d = (pwr_q & ~clr_wr) | req_wr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      gid_q   <= '0;
      rr_q    <= '0;
      lba_q   <= '0;
      prd_q   <= '0;
      pwr_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      lba_q   <= lba_d;
      prd_q   <= prd_d;
      pwr_q   <= pwr_d;
    end
  end

  always_comb begin
    sdc_rd  = '0;
    sdc_wr  = '0;
    ch_busy = '0;
    unique case (state_q)
      IDLE: ch_busy = wp_mask;
      REQ, XFER: ch_busy = gnt_oh & {NCH{sdc_busy}};
      default: ch_busy = '0;
    endcase
    if (state_q == REQ) begin
      if (op_q == OP_RD) sdc_rd = gnt_oh;
      else sdc_wr = gnt_oh;
    end
  end

  assign sdc_lba      = lba_q;
  assign grant_id     = gid_q;
  assign sdc_data_out = reset ? 8'h00 : req_dout[int'(gid_q)*8 +: 8];

  for (genvar i = 0; i < NCH; i++) begin : g_led
    activity_led_timer #(
      .LED_W(LED_W)
    ) u_led (
      .clk   (clk),
      .reset (reset),
      .load  (led_load[i]),
      .active(led[i])
    );
  end

endmodule
